// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_rst_pkg
// Description : Shared definitions for the PLL lock supervisor / reset
//               sequencer and the PLL wrappers that feed it: sequencer state
//               type, default timing constants and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_rst_pkg;

    // Sequencer states. Explicit 2-bit encoding keeps the state register
    // width fixed regardless of tool enum defaults.
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    // Default timing constants, shared with the PLL wrappers so every
    // instance of the sequencer agrees with the wrapper it supervises.
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_LOCK_TIMEOUT       = 65536;
    localparam int DEF_RESETB_PULSE       = 16;
    localparam int DEF_NUM_RESETS         = 3;
    localparam int DEF_RELEASE_GAP        = 8;
    localparam int DEF_LOSS_CNT_W         = 8;
    localparam int DEF_SYNC_STAGES        = 2;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage : clk_rst_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Generic single-bit synchroniser chain. The input is sampled
//               into a chain of STAGES flops; q is the last flop.
//               Ports:
//                 clk  in  1  destination clock
//                 rst  in  1  synchronous, active-high; chain loads RESET_VAL
//                 d    in  1  asynchronous input bit
//                 q    out 1  synchronised bit, STAGES cycles of latency
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (STAGES < 2) begin : g_param_check
            $fatal(1, "sync_ff: STAGES must be at least 2");
        end
    endgenerate

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Lock supervisor and reset sequencer for an SB_PLL40-style PLL,
//               clocked by the PLL reference clock. Pulses the PLL RESETB,
//               waits for a debounced LOCK, then releases the domain resets
//               one by one. Lock loss after release starts re-asserts every
//               domain reset and goes back to waiting for lock; failing to
//               lock within the timeout resets the PLL again.
//               Ports:
//                 clock_in      in   1           reference clock (only clock)
//                 reset         in   1           synchronous, active-high
//                 pll_locked    in   1           PLL LOCK, asynchronous
//                 clear_status  in   1           pulse: clear lock_lost/loss_count
//                 pll_resetb    out  1           PLL RESETB, active-low
//                 domain_reset  out  NUM_RESETS  active-high, bit 0 released first
//                 ready         out  1           all domains out of reset, locked
//                 lock_lost     out  1           sticky lock-loss flag
//                 loss_count    out  LOSS_CNT_W  saturating lock-loss count
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
    parameter int RESETB_PULSE       = DEF_RESETB_PULSE,
    parameter int NUM_RESETS         = DEF_NUM_RESETS,
    parameter int RELEASE_GAP        = DEF_RELEASE_GAP,
    parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W,
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  clear_status,
    output logic                  pll_resetb,
    output logic [NUM_RESETS-1:0] domain_reset,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    generate
        if (LOCK_STABLE_CYCLES < 1 || LOCK_TIMEOUT <= LOCK_STABLE_CYCLES ||
            RESETB_PULSE < 1 || NUM_RESETS < 1 || RELEASE_GAP < 1 ||
            LOSS_CNT_W < 1 || SYNC_STAGES < 2) begin : g_param_check
            $fatal(1, "pll_reset_sequencer: illegal parameter combination");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Counter geometry
    // ------------------------------------------------------------------------
    localparam int RELEASE_SPAN = RELEASE_GAP * NUM_RESETS;
    localparam int STABLE_W     = cnt_width(LOCK_STABLE_CYCLES);
    localparam int TIMEOUT_W    = cnt_width(LOCK_TIMEOUT);
    localparam int PULSE_W      = cnt_width(RESETB_PULSE);
    localparam int RELEASE_W    = cnt_width(RELEASE_SPAN);

    localparam logic [STABLE_W-1:0]   STABLE_LIMIT  = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [TIMEOUT_W-1:0]  TIMEOUT_LIMIT = TIMEOUT_W'(LOCK_TIMEOUT);
    localparam logic [PULSE_W-1:0]    PULSE_LAST    = PULSE_W'(RESETB_PULSE - 1);
    localparam logic [RELEASE_W-1:0]  RELEASE_LIMIT = RELEASE_W'(RELEASE_SPAN);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX      = {LOSS_CNT_W{1'b1}};
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE      = LOSS_CNT_W'(1);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    seq_state_t             r_state;
    seq_state_t             w_state_nxt;

    logic [PULSE_W-1:0]     r_pulse_cnt;
    logic [PULSE_W-1:0]     w_pulse_nxt;
    logic [STABLE_W-1:0]    r_stable_cnt;
    logic [STABLE_W-1:0]    w_stable_nxt;
    logic [TIMEOUT_W-1:0]   r_timeout_cnt;
    logic [TIMEOUT_W-1:0]   w_timeout_nxt;
    logic [RELEASE_W-1:0]   r_release_cnt;
    logic [RELEASE_W-1:0]   w_release_nxt;

    logic                   w_lock_s;
    logic                   w_loss;

    logic                   w_resetb_nxt;
    logic [NUM_RESETS-1:0]  w_domain_nxt;
    logic                   w_ready_nxt;
    logic                   w_lost_nxt;
    logic [LOSS_CNT_W-1:0]  w_count_nxt;

    // ------------------------------------------------------------------------
    // LOCK synchroniser
    // ------------------------------------------------------------------------
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk (clock_in),
        .rst (reset),
        .d   (pll_locked),
        .q   (w_lock_s)
    );

    // Lock drops only count as losses once domain resets have started to
    // release; while still waiting for lock they merely restart debouncing.
    assign w_loss = ((r_state == RELEASE) || (r_state == RUN)) && !w_lock_s;

    // ------------------------------------------------------------------------
    // State register, counters and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state       <= PLL_RST;
            r_pulse_cnt   <= '0;
            r_stable_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_release_cnt <= '0;
            pll_resetb    <= 1'b0;
            domain_reset  <= '1;
            ready         <= 1'b0;
            lock_lost     <= 1'b0;
            loss_count    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pulse_cnt   <= w_pulse_nxt;
            r_stable_cnt  <= w_stable_nxt;
            r_timeout_cnt <= w_timeout_nxt;
            r_release_cnt <= w_release_nxt;
            pll_resetb    <= w_resetb_nxt;
            domain_reset  <= w_domain_nxt;
            ready         <= w_ready_nxt;
            lock_lost     <= w_lost_nxt;
            loss_count    <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic. Every counter defaults to zero, so a
    // counter is automatically clear on entry to the state that uses it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pulse_nxt   = '0;
        w_stable_nxt  = '0;
        w_timeout_nxt = '0;
        w_release_nxt = '0;

        case (r_state)
            PLL_RST: begin
                if (r_pulse_cnt == PULSE_LAST) begin
                    w_state_nxt = WAIT_LOCK;
                end else begin
                    w_pulse_nxt = r_pulse_cnt + 1'b1;
                end
            end

            WAIT_LOCK: begin
                w_stable_nxt  = w_lock_s ? (r_stable_cnt + 1'b1) : '0;
                w_timeout_nxt = r_timeout_cnt + 1'b1;
                // A lock qualifying on the very cycle the timeout expires is
                // honoured rather than thrown away by a PLL reset.
                if (w_stable_nxt == STABLE_LIMIT) begin
                    w_state_nxt   = RELEASE;
                    w_stable_nxt  = '0;
                    w_timeout_nxt = '0;
                end else if (w_timeout_nxt == TIMEOUT_LIMIT) begin
                    w_state_nxt   = PLL_RST;
                    w_stable_nxt  = '0;
                    w_timeout_nxt = '0;
                end
            end

            RELEASE: begin
                if (w_loss) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_release_cnt == RELEASE_LIMIT) begin
                    w_state_nxt = RUN;
                end else begin
                    w_release_nxt = r_release_cnt + 1'b1;
                end
            end

            RUN: begin
                if (w_loss) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end

            default: begin
                w_state_nxt = PLL_RST;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_resetb_nxt = (w_state_nxt != PLL_RST);
        w_ready_nxt  = (w_state_nxt == RUN);

        // Domain resets: all asserted outside RELEASE/RUN. Inside RELEASE a
        // bit only ever clears, at its own offset from RELEASE entry, so the
        // release order is strictly ascending.
        w_domain_nxt = '1;
        if (w_state_nxt == RUN) begin
            w_domain_nxt = '0;
        end else if (w_state_nxt == RELEASE) begin
            w_domain_nxt = (r_state == RELEASE) ? domain_reset : '1;
            for (int i = 0; i < NUM_RESETS; i++) begin
                if (int'(w_release_nxt) == RELEASE_GAP * (i + 1)) begin
                    w_domain_nxt[i] = 1'b0;
                end
            end
        end

        // Status: a loss in the same cycle as clear_status wins, leaving a
        // count of exactly one for the new event.
        w_lost_nxt  = lock_lost;
        w_count_nxt = loss_count;
        if (w_loss) begin
            w_lost_nxt = 1'b1;
            if (clear_status) begin
                w_count_nxt = LOSS_ONE;
            end else if (loss_count != LOSS_MAX) begin
                w_count_nxt = loss_count + 1'b1;
            end
        end else if (clear_status) begin
            w_lost_nxt  = 1'b0;
            w_count_nxt = '0;
        end
    end

endmodule : pll_reset_sequencer
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer. Directed
//               sequences plus randomized lock/clear/reset activity, compared
//               every cycle against a phase/elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int STABLE  = 8;
    localparam int TIMEOUT = 64;
    localparam int PULSE   = 4;
    localparam int NRST    = 3;
    localparam int GAP     = 2;
    localparam int SYNC    = 2;
    localparam int LW      = 2;
    localparam int LMAX    = (1 << LW) - 1;

    localparam int PH_PULSE   = 0;
    localparam int PH_WAIT    = 1;
    localparam int PH_RELEASE = 2;
    localparam int PH_RUN     = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            locked = 1'b0;
    logic            clr = 1'b0;
    logic            pll_resetb;
    logic [NRST-1:0] domain_reset;
    logic            ready;
    logic            lock_lost;
    logic [LW-1:0]   loss_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current phase, edges spent in it, consecutive
    // synced-lock count, the synchroniser pipeline and the status.
    int             m_phase;
    int             m_t;
    int             m_stable;
    int             m_cnt;
    bit             m_lost;
    logic [SYNC-1:0] m_sync;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT       (TIMEOUT),
        .RESETB_PULSE       (PULSE),
        .NUM_RESETS         (NRST),
        .RELEASE_GAP        (GAP),
        .LOSS_CNT_W         (LW),
        .SYNC_STAGES        (SYNC)
    ) dut (
        .clock_in     (clk),
        .reset        (rst),
        .pll_locked   (locked),
        .clear_status (clr),
        .pll_resetb   (pll_resetb),
        .domain_reset (domain_reset),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .loss_count   (loss_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step(input bit r, input bit l, input bit c);
        bit ls;
        bit loss;
        if (r) begin
            m_phase  = PH_PULSE;
            m_t      = 0;
            m_stable = 0;
            m_cnt    = 0;
            m_lost   = 0;
            m_sync   = '0;
            return;
        end
        ls     = m_sync[SYNC-1];
        m_sync = {m_sync[SYNC-2:0], l};
        loss   = (m_phase == PH_RELEASE || m_phase == PH_RUN) && !ls;

        if (loss) begin
            m_lost = 1;
            m_cnt  = c ? 1 : ((m_cnt < LMAX) ? m_cnt + 1 : LMAX);
        end else if (c) begin
            m_lost = 0;
            m_cnt  = 0;
        end

        case (m_phase)
            PH_PULSE: begin
                m_t++;
                if (m_t == PULSE) begin
                    m_phase = PH_WAIT; m_t = 0; m_stable = 0;
                end
            end
            PH_WAIT: begin
                m_t++;
                m_stable = ls ? m_stable + 1 : 0;
                if (m_stable == STABLE) begin
                    m_phase = PH_RELEASE; m_t = 0;
                end else if (m_t == TIMEOUT) begin
                    m_phase = PH_PULSE; m_t = 0;
                end
            end
            PH_RELEASE: begin
                if (loss) begin
                    m_phase = PH_WAIT; m_t = 0; m_stable = 0;
                end else if (m_t == GAP * NRST) begin
                    m_phase = PH_RUN; m_t = 0;
                end else begin
                    m_t++;
                end
            end
            default: begin
                if (loss) begin
                    m_phase = PH_WAIT; m_t = 0; m_stable = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        logic [NRST-1:0] e_dr;
        for (int i = 0; i < NRST; i++) begin
            if (m_phase == PH_RUN)          e_dr[i] = 1'b0;
            else if (m_phase == PH_RELEASE) e_dr[i] = (m_t < GAP * (i + 1));
            else                            e_dr[i] = 1'b1;
        end
        check("pll_resetb",   32'(pll_resetb),   32'(m_phase != PH_PULSE));
        check("domain_reset", 32'(domain_reset), 32'(e_dr));
        check("ready",        32'(ready),        32'(m_phase == PH_RUN));
        check("lock_lost",    32'(lock_lost),    32'(m_lost));
        check("loss_count",   32'(loss_count),   32'(m_cnt));
    endtask

    task automatic cycle(input bit r, input bit l, input bit c);
        @(negedge clk);
        rst    = r;
        locked = l;
        clr    = c;
        @(posedge clk);
        model_step(r, l, c);
        #1;
        compare_all();
    endtask

    function automatic bit loss_pending();
        return (m_phase == PH_RELEASE || m_phase == PH_RUN) && !m_sync[SYNC-1];
    endfunction

    // Drive one cycle; clear_status is sometimes aimed at a pending loss.
    task automatic drive(input bit r, input bit l);
        bit c;
        bit aimed;
        aimed = !r && loss_pending() && ($urandom_range(0, 1) == 1);
        c = aimed || ($urandom_range(0, 31) == 0);
        cycle(r, l, c);
        if (aimed) begin
            check("clr_vs_loss_lost", 32'(lock_lost),  32'd1);
            check("clr_vs_loss_cnt",  32'(loss_count), 32'd1);
        end
    endtask

    initial begin
        int k;
        m_phase = PH_PULSE; m_t = 0; m_stable = 0; m_cnt = 0; m_lost = 0; m_sync = '0;

        // Reset and its values.
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        check("rst_resetb", 32'(pll_resetb),   32'd0);
        check("rst_domain", 32'(domain_reset), 32'b111);

        // Locked throughout: full sequence to RUN.
        for (int i = 0; i < 40; i++) cycle(0, 1, 0);
        check("run_ready", 32'(ready), 32'd1);

        // Single-cycle lock dips in RUN, saturating the loss counter.
        for (int d = 0; d < 5; d++) begin
            cycle(0, 0, 0);
            for (int i = 0; i < 30; i++) cycle(0, 1, 0);
        end
        check("sat_count", 32'(loss_count), 32'(LMAX));

        // Reset mid-RELEASE with domain_reset at 100.
        k = 0;
        cycle(0, 0, 0);
        while (k < 200 && !(m_phase == PH_RELEASE && m_t == 2 * GAP)) begin
            cycle(0, 1, 0);
            k++;
        end
        check("reach_mid_release", 32'(domain_reset), 32'b100);
        cycle(1, 1, 0);
        check("mid_rel_rst_domain", 32'(domain_reset), 32'b111);
        check("mid_rel_rst_resetb", 32'(pll_resetb),   32'd0);

        // Lock never arrives: repeated PLL reset pulses.
        for (int i = 0; i < 150; i++) cycle(0, 0, 0);

        // Randomized segments.
        for (int s = 0; s < 80; s++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 9));
            if (kind <= 4) begin
                len = int'($urandom_range(5, 60));
                for (int i = 0; i < len; i++) drive(0, 1);
            end else if (kind <= 6) begin
                len = int'($urandom_range(1, 3));
                for (int i = 0; i < len; i++) drive(0, 0);
            end else if (kind == 7) begin
                len = int'($urandom_range(60, 150));
                for (int i = 0; i < len; i++) drive(0, 0);
            end else if (kind == 8) begin
                len = int'($urandom_range(1, 2));
                for (int i = 0; i < len; i++) drive(1, 1'($urandom_range(0, 1)));
            end else begin
                len = int'($urandom_range(5, 30));
                for (int i = 0; i < len; i++) drive(0, 1'($urandom_range(0, 7) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pll_reset_sequencer
`default_nettype wire
